vt_seq_decode: RTL and testbench

//  Sequential Varshamov-Tenengolts decoder, successor to the combinational vt_decode.

---
 rtl/vt_pkg.sv | 43 ++++
 rtl/vt_data_extract.sv | 16 +
 rtl/vt_seq_decode.sv | 171 +++++++++++++++++
 tb/tb_vt_seq_decode.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vt_pkg.sv
// Shared types and elaboration helpers for the VT decoder family:
// status/state encodings and systematic data-position mapping.
package vt_pkg;

  typedef enum logic [1:0] {
    CLEAN     = 2'b00,
    CORRECTED = 2'b01,
    UNCORR    = 2'b10
  } vt_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE,
    S_INSERT,
    S_BUILD,
    S_EMIT
  } vt_state_e;

  function automatic bit is_pow2(int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  function automatic int vt_k(int n);
    return n - $clog2(n + 1);
  endfunction

  // 1-based word position carrying data bit k (data sits at non-power-of-2 positions)
  function automatic int vt_data_pos(int n, int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 1;
    for (int p = 1; p <= n; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/vt_data_extract.sv
// Combinational extraction of the K systematic data bits from an N-bit VT word.
module vt_data_extract
  import vt_pkg::*;
#(
  parameter int N = 12,
  localparam int K = vt_k(N)
) (
  input  logic [N-1:0] word,
  output logic [K-1:0] data
);

  for (genvar k = 0; k < K; k++) begin : g_bit
    assign data[k] = word[vt_data_pos(N, k) - 1];
  end

endmodule

// File: rtl/vt_seq_decode.sv
// Bit-serial Varshamov-Tenengolts decoder with single-deletion correction.
// Define VT_STATS_EN to add saturating corrected/uncorrectable counters.
module vt_seq_decode
  import vt_pkg::*;
#(
  parameter int N            = 12,
  parameter int SYNDROME_VAL = 0,
  localparam int K           = vt_k(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_del,
  input  logic [N-1:0] in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic [1:0]   out_status
`ifdef VT_STATS_EN
  ,
  output logic [15:0]  cnt_corr,
  output logic [15:0]  cnt_uncorr
`endif
);

  localparam int CW = $clog2(N + 1);
  localparam int AW = CW + 1;
  localparam logic [AW-1:0] MOD = AW'(N + 1);
  localparam logic [AW-1:0] SV  = AW'(SYNDROME_VAL);

  vt_state_e  state, state_nx;
  vt_status_e status_r, out_status_r;
  logic [N-1:0]  word_r, cw_r, word_sh, ins_word;
  logic [K-1:0]  out_data_r, data_x;
  logic          del_r, ins_bit_r;
  logic [CW-1:0] len_r, idx_r, w_r, p_r, ones_r, zeros_r;
  logic [AW-1:0] acc_r, tgt_r, acc_sum, acc_nx, d_raw, d_val, w_ext;
  logic          bit_cur, y_p, match, scan_end;

  // SCAN datapath: weighted residue of the received word
  assign bit_cur  = word_r[0] & (idx_r == CW'(1)) | ((word_r >> (idx_r - 1'b1)) & N'(1)) != '0;
  assign acc_sum  = acc_r + (bit_cur ? AW'(idx_r) : '0);
  assign acc_nx   = (acc_sum >= MOD) ? acc_sum - MOD : acc_sum;
  assign scan_end = (idx_r == len_r);

  // D = (a - acc) mod (N+1); adding MOD first keeps the difference non-negative
  assign d_raw = SV + MOD - acc_r;
  assign d_val = (d_raw >= MOD) ? d_raw - MOD : d_raw;
  assign w_ext = AW'(w_r);

  // INSERT: prefix counts cover y[1..p]; suffix ones = w - prefix ones
  assign y_p   = ((word_r >> p_r) & N'(1)) != '0;
  assign match = ins_bit_r ? (AW'(zeros_r) == tgt_r) : (AW'(w_r - ones_r) == tgt_r);

  assign word_sh = {word_r[N-2:0], 1'b0};
  always_comb begin
    ins_word = '0;
    for (int j = 0; j < N; j++) begin
      if (CW'(j) < p_r)       ins_word[j] = word_r[j];
      else if (CW'(j) == p_r) ins_word[j] = ins_bit_r;
      else                    ins_word[j] = word_sh[j];
    end
  end

  vt_data_extract #(.N(N)) u_extract (
    .word (cw_r),
    .data (data_x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (in_valid)            state_nx = S_SCAN;
      S_SCAN:   if (scan_end)            state_nx = S_DECIDE;
      S_DECIDE:                          state_nx = del_r ? S_INSERT : S_BUILD;
      S_INSERT: if (match || p_r == len_r) state_nx = S_BUILD;
      S_BUILD:                           state_nx = S_EMIT;
      S_EMIT:   if (out_ready)           state_nx = S_IDLE;
      default:                           state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r       <= '0;
      cw_r         <= '0;
      del_r        <= 1'b0;
      len_r        <= '0;
      idx_r        <= '0;
      w_r          <= '0;
      acc_r        <= '0;
      p_r          <= '0;
      ones_r       <= '0;
      zeros_r      <= '0;
      tgt_r        <= '0;
      ins_bit_r    <= 1'b0;
      status_r     <= CLEAN;
      out_status_r <= CLEAN;
      out_data_r   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          // a short word gets a 0 at position N so the unmatched case is already padded
          word_r <= in_del ? {1'b0, in_word[N-2:0]} : in_word;
          del_r  <= in_del;
          len_r  <= in_del ? CW'(N - 1) : CW'(N);
          acc_r  <= '0;
          w_r    <= '0;
          idx_r  <= CW'(1);
        end
        S_SCAN: begin
          acc_r <= acc_nx;
          w_r   <= w_r + CW'(bit_cur);
          idx_r <= idx_r + 1'b1;
        end
        S_DECIDE: begin
          p_r     <= '0;
          ones_r  <= '0;
          zeros_r <= '0;
          cw_r    <= word_r;
          if (!del_r) status_r <= (d_val == '0) ? CLEAN : UNCORR;
          else begin
            ins_bit_r <= (d_val > w_ext);
            tgt_r     <= (d_val > w_ext) ? d_val - w_ext - 1'b1 : d_val;
          end
        end
        S_INSERT: begin
          if (match) begin
            cw_r     <= ins_word;
            status_r <= CORRECTED;
          end else if (p_r == len_r) begin
            status_r <= UNCORR;
          end else begin
            p_r     <= p_r + 1'b1;
            ones_r  <= ones_r + CW'(y_p);
            zeros_r <= zeros_r + CW'(!y_p);
          end
        end
        S_BUILD: begin
          out_data_r   <= data_x;
          out_status_r <= status_r;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_EMIT);
  assign out_data   = out_data_r;
  assign out_status = out_status_r;

`ifdef VT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (state == S_EMIT && out_ready) begin
      if (out_status_r == CORRECTED && cnt_corr != 16'hFFFF)  cnt_corr   <= cnt_corr + 16'd1;
      if (out_status_r == UNCORR && cnt_uncorr != 16'hFFFF)   cnt_uncorr <= cnt_uncorr + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vt_seq_decode.sv
// Directed bench for vt_seq_decode (N=12, a=0): vector table plus
// back-pressure and mid-scan reset sequences.
module tb_vt_seq_decode;
  import vt_pkg::*;

  localparam int N = 12;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_del = 1'b0;
  logic [N-1:0] in_word = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [K-1:0] out_data;
  logic [1:0]   out_status;
`ifdef VT_STATS_EN
  logic [15:0]  cnt_corr, cnt_uncorr;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vt_seq_decode #(.N(N), .SYNDROME_VAL(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_del     (in_del),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status)
`ifdef VT_STATS_EN
    ,
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr)
`endif
  );

  typedef struct {
    logic         del;
    logic [N-1:0] word;
    logic [K-1:0] data;
    logic [1:0]   status;
    string        name;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one word at a negedge, let it be accepted, then count negedges until out_valid
  task automatic send(input logic del, input logic [N-1:0] word, output int lat, output bit ok);
    @(negedge clk);
    in_valid = 1'b1;
    in_del   = del;
    in_word  = word;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  ok;
    bit  stable;

    vecs[0] = '{1'b0, 12'h01D, 8'h03, 2'b00, "clean"};
    vecs[1] = '{1'b1, 12'h80D, 8'h03, 2'b01, "del_one"};   // bit 11 is don't-care for a short word
    vecs[2] = '{1'b1, 12'h00F, 8'h03, 2'b01, "del_zero"};
    vecs[3] = '{1'b0, 12'h01C, 8'h03, 2'b10, "subst"};

    repeat (3) @(negedge clk);
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_data",   out_data,   0);
    chk("rst_out_status", out_status, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      chk({vecs[v].name, "_in_ready"}, in_ready, 1);
      send(vecs[v].del, vecs[v].word, lat, ok);
      chk({vecs[v].name, "_timeout"}, ok, 1);
      if (v == 0) chk("clean_latency", lat, 15);
      chk({vecs[v].name, "_data"},   out_data,   vecs[v].data);
      chk({vecs[v].name, "_status"}, out_status, vecs[v].status);
      chk({vecs[v].name, "_busy"},   in_ready,   0);
      release_out();
      chk({vecs[v].name, "_done"},   out_valid,  0);
    end

`ifdef VT_STATS_EN
    chk("cnt_corr",   cnt_corr,   2);
    chk("cnt_uncorr", cnt_uncorr, 1);
`endif

    // Back-pressure: result must hold while the sink stalls
    send(1'b0, 12'h01D, lat, ok);
    chk("bp_timeout", ok, 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h03 || out_status !== 2'b00 || in_ready !== 1'b0)
        stable = 1'b0;
      @(negedge clk);
    end
    chk("bp_stable", stable, 1);
    release_out();
    chk("bp_release", in_ready, 1);

    // Reset in the middle of a scan
    @(negedge clk);
    in_valid = 1'b1;
    in_del   = 1'b0;
    in_word  = 12'h01C;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",   in_ready,   1);
    chk("mid_rst_out_valid",  out_valid,  0);
    chk("mid_rst_out_data",   out_data,   0);
    chk("mid_rst_out_status", out_status, 0);
`ifdef VT_STATS_EN
    chk("mid_rst_cnt_corr",   cnt_corr,   0);
    chk("mid_rst_cnt_uncorr", cnt_uncorr, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 12'h01D, lat, ok);
    chk("post_rst_timeout", ok, 1);
    chk("post_rst_latency", lat, 15);
    chk("post_rst_data",   out_data,   8'h03);
    chk("post_rst_status", out_status, 2'b00);
    release_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
